// File: rtl/cs_resolve_modsub.sv
// cs_resolve_modsub: chunked carry-propagate resolve of a carry-save pair with one trial modulus subtraction
module cs_resolve_modsub #(
  parameter int N = 256,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   s,
  input  logic [N:0]   c,
  input  logic [N-1:0] m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   r,
  output logic         ovf
);
  localparam int K  = (N + W) / W;
  localparam int P  = K * W;
  localparam int IW = $clog2(K + 1);
  localparam logic [P:0] MASK = ((P+1)'(1) << (N + 1)) - (P+1)'(1);
  typedef enum logic [1:0] {IDLE, RUN, SEL, HOLD} state_t;
  state_t r_state, w_next;
  logic [P-1:0] r_s, r_c, r_m, r_mk, r_sum, r_dif;
  logic r_carry, r_borrow;
  logic [IW-1:0] r_idx;
  logic [W:0] w_add, w_sub;
  assign w_add = {1'b0, r_s[W-1:0]} + {1'b0, r_c[W-1:0]} + {{W{1'b0}}, r_carry};
  // the trial subtraction sees the sum truncated to N+1 bits, so padded bits above N are masked off
  assign w_sub = {1'b0, w_add[W-1:0] & r_mk[W-1:0]} - {1'b0, r_m[W-1:0]} - {{W{1'b0}}, r_borrow};
  assign in_ready = r_state == IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = (r_idx == IW'(K - 1)) ? SEL : RUN;
      SEL:     w_next = HOLD;
      HOLD:    w_next = out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_c       <= '0;
      r_m       <= '0;
      r_mk      <= '0;
      r_sum     <= '0;
      r_dif     <= '0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_idx     <= '0;
      r         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (in_valid) begin
          r_s      <= P'(s);
          r_c      <= P'(c);
          r_m      <= P'(m);
          r_mk     <= MASK[P-1:0];
          r_carry  <= 1'b0;
          r_borrow <= 1'b0;
          r_idx    <= '0;
        end
        RUN: begin
          r_s      <= r_s >> W;
          r_c      <= r_c >> W;
          r_m      <= r_m >> W;
          r_mk     <= r_mk >> W;
          r_sum    <= {w_add[W-1:0], r_sum[P-1:W]};
          r_dif    <= {w_sub[W-1:0], r_dif[P-1:W]};
          r_carry  <= w_add[W];
          r_borrow <= w_sub[W];
          r_idx    <= r_idx + IW'(1);
        end
        SEL: begin
          r         <= r_borrow ? r_sum[N:0] : r_dif[N:0];
          ovf       <= r_carry | (|(r_sum >> (N + 1)));
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cs_resolve_modsub.sv
// tb_cs_resolve_modsub: directed checks on N=8/W=4 plus golden-model checks on N=256/W=64
module tb_cs_resolve_modsub;
  logic clk, rst_n;
  logic in_valid, in_ready, out_valid, out_ready, ovf;
  logic [8:0] s, c, r;
  logic [7:0] m;
  logic b_in_valid, b_in_ready, b_out_valid, b_ovf;
  logic [256:0] bs, bc, br;
  logic [255:0] bm;
  int total = 0;
  int bad = 0;

  cs_resolve_modsub #(.N(8), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .c(c), .m(m), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .ovf(ovf)
  );

  cs_resolve_modsub #(.N(256), .W(64)) dut_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .s(bs), .c(bc), .m(bm), .out_valid(b_out_valid), .out_ready(out_ready),
    .r(br), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [8:0] ts, input logic [8:0] tc,
                    input logic [7:0] tm, input logic [8:0] er, input logic eo);
    int n;
    s = ts; c = tc; m = tm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, 257'(n), 257'(4));
    check({tag, "_r"}, 257'(r), 257'(er));
    check({tag, "_ovf"}, 257'(ovf), 257'(eo));
  endtask

  task automatic handshake(input string tag);
    @(posedge clk); #1;
    check({tag, "_ov_clr"}, 257'(out_valid), 257'(0));
    check({tag, "_ir"}, 257'(in_ready), 257'(1));
  endtask

  task automatic bop(input string tag);
    logic [257:0] sum;
    logic [256:0] t, er;
    int n;
    sum = {1'b0, bs} + {1'b0, bc};
    t = sum[256:0];
    er = (t >= {1'b0, bm}) ? t - {1'b0, bm} : t;
    b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 30) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, 257'(n), 257'(6));
    check({tag, "_r"}, br, er);
    check({tag, "_ovf"}, 257'(b_ovf), 257'(sum[257]));
    @(posedge clk); #1;
    check({tag, "_ov_clr"}, 257'(b_out_valid), 257'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; s = '0; c = '0; m = '0;
    b_in_valid = 1'b0; bs = '0; bc = '0; bm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", 257'(out_valid), 257'(0));
    check("rst_r", 257'(r), 257'(0));
    check("rst_ovf", 257'(ovf), 257'(0));
    check("rst_ir", 257'(in_ready), 257'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;
    op("t1", 9'h0F0, 9'h01E, 8'hC5, 9'h049, 1'b0);
    handshake("t1");
    op("t2", 9'h010, 9'h004, 8'hC5, 9'h014, 1'b0);
    handshake("t2");
    op("t3", 9'h0C0, 9'h005, 8'hC5, 9'h000, 1'b0);
    handshake("t3");
    op("t4", 9'h1FF, 9'h002, 8'hC5, 9'h001, 1'b1);
    handshake("t4");
    out_ready = 1'b0;
    op("t5", 9'h010, 9'h004, 8'hC5, 9'h014, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      s = 9'h1AA; c = 9'h022; m = 8'h10;
      @(posedge clk); #1;
      check("t5_hold_ov", 257'(out_valid), 257'(1));
      check("t5_hold_r", 257'(r), 257'(9'h014));
      check("t5_hold_ovf", 257'(ovf), 257'(0));
      check("t5_hold_ir", 257'(in_ready), 257'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    handshake("t5");
    @(posedge clk); #1;
    check("t5_no_ghost", 257'(out_valid), 257'(0));
    s = 9'h0F0; c = 9'h01E; m = 8'hC5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ov", 257'(out_valid), 257'(0));
    check("t6_rst_r", 257'(r), 257'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_ir", 257'(in_ready), 257'(1));
    check("t6_ov", 257'(out_valid), 257'(0));
    op("t6_t1", 9'h0F0, 9'h01E, 8'hC5, 9'h049, 1'b0);
    handshake("t6_t1");
    bs = '1; bc = 257'd2; bm = 256'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001;
    bop("big_ovf");
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        bs[i*32 +: 32] = $urandom;
        bc[i*32 +: 32] = $urandom;
        bm[i*32 +: 32] = $urandom;
      end
      bs[256:255] = 2'b00;
      bc[256:255] = 2'b00;
      bc[0] = 1'b0;
      bm[255] = 1'b1;
      bop($sformatf("big_rnd%0d", k));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
